// File: rtl/floo_test_pkg.sv
// Shared types for the floo AXI transaction monitor: FSM state encoding and
// outstanding-counter sizing.
package floo_test_pkg;

  typedef enum logic [2:0] {
    MON_IDLE   = 3'd0,
    MON_ACTIVE = 3'd1,
    MON_DRAIN  = 3'd2,
    MON_DONE   = 3'd3,
    MON_ERROR  = 3'd4
  } mon_state_e;

  // Bits needed to hold 0..max_outstanding inclusive.
  function automatic int unsigned out_cnt_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/floo_txn_outstanding_ctr.sv
// Saturating up/down in-flight counter. Underflow/overflow flags are
// combinational and pulse in the cycle the offending handshake is seen.
module floo_txn_outstanding_ctr #(
  parameter int unsigned MaxCount = 32,
  parameter int unsigned Width    = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic [Width-1:0] count_next_o,
  output logic             underflow_o,
  output logic             overflow_o
);

  localparam logic [Width-1:0] One = Width'(1);
  localparam logic [Width-1:0] Max = Width'(MaxCount);

  logic [Width-1:0] count_q;

  // Simultaneous inc and dec cancel; out-of-range moves hold the count.
  always_comb begin
    count_next_o = count_q;
    underflow_o  = 1'b0;
    overflow_o   = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == Max) overflow_o = 1'b1;
      else                count_next_o = count_q + One;
    end else if (dec_i && !inc_i) begin
      if (count_q == '0) underflow_o = 1'b1;
      else               count_next_o = count_q - One;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_next_o;
  end

  assign count_o = count_q;

endmodule

// File: rtl/floo_axi_txn_monitor.sv
// Passive AXI handshake monitor: outstanding tracking, completion counts,
// sticky error/timeout and drain-qualified done. Optional per-channel request
// stall counters are enabled by FLOO_AXI_TXN_MONITOR_STALL_CNT_EN.
module floo_axi_txn_monitor
  import floo_test_pkg::*;
#(
  parameter  int unsigned MaxOutstanding = 32,
  parameter  int unsigned TimeoutCycles  = 4096,
  parameter  int unsigned CntWidth       = 32,
  localparam int unsigned OutW           = out_cnt_width(MaxOutstanding)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                aw_valid_i,
  input  logic                aw_ready_i,
  input  logic                w_valid_i,
  input  logic                w_ready_i,
  input  logic                w_last_i,
  input  logic                b_valid_i,
  input  logic                b_ready_i,
  input  logic                ar_valid_i,
  input  logic                ar_ready_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  input  logic                end_of_sim_i,
  output logic [OutW-1:0]     wr_outstanding_o,
  output logic [OutW-1:0]     rd_outstanding_o,
  output logic [CntWidth-1:0] wr_done_cnt_o,
  output logic [CntWidth-1:0] rd_done_cnt_o,
  output logic                done_o,
  output logic                error_o,
  output logic                timeout_o,
`ifdef FLOO_AXI_TXN_MONITOR_STALL_CNT_EN
  output logic [CntWidth-1:0] aw_stall_cnt_o,
  output logic [CntWidth-1:0] ar_stall_cnt_o,
`endif
  output mon_state_e          state_o
);

  localparam int unsigned      WdW    = $clog2(TimeoutCycles);
  localparam logic [WdW-1:0]   WdLast = WdW'(TimeoutCycles - 1);
  localparam logic [WdW-1:0]   WdOne  = WdW'(1);

  // A transfer happens on a channel only when valid and ready are both high.
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last_hs, progress;
  assign aw_hs     = aw_valid_i & aw_ready_i;
  assign w_hs      = w_valid_i & w_ready_i;
  assign b_hs      = b_valid_i & b_ready_i;
  assign ar_hs     = ar_valid_i & ar_ready_i;
  assign r_hs      = r_valid_i & r_ready_i;
  assign r_last_hs = r_hs & r_last_i;
  assign progress  = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  logic unused_w_last;
  assign unused_w_last = w_last_i;

  logic [OutW-1:0] wr_cnt, wr_cnt_next, rd_cnt, rd_cnt_next;
  logic            wr_uf, wr_of, rd_uf, rd_of;

  floo_txn_outstanding_ctr #(.MaxCount(MaxOutstanding), .Width(OutW)) i_wr_ctr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inc_i        (aw_hs),
    .dec_i        (b_hs),
    .count_o      (wr_cnt),
    .count_next_o (wr_cnt_next),
    .underflow_o  (wr_uf),
    .overflow_o   (wr_of)
  );

  floo_txn_outstanding_ctr #(.MaxCount(MaxOutstanding), .Width(OutW)) i_rd_ctr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inc_i        (ar_hs),
    .dec_i        (r_last_hs),
    .count_o      (rd_cnt),
    .count_next_o (rd_cnt_next),
    .underflow_o  (rd_uf),
    .overflow_o   (rd_of)
  );

  logic [WdW-1:0] wd_q;
  logic           wd_clear, wd_hit;
  assign wd_clear = progress | ((wr_cnt == '0) & (rd_cnt == '0));
  assign wd_hit   = !wd_clear && (wd_q == WdLast);

  always_ff @(posedge clk_i) begin
    if (rst_i)          wd_q <= '0;
    else if (wd_clear)  wd_q <= '0;
    else if (!wd_hit)   wd_q <= wd_q + WdOne;
  end

  mon_state_e state_q, state_d;
  logic       err_set;
  assign err_set = wr_uf | wr_of | rd_uf | rd_of
                 | ((state_q == MON_DONE) & (aw_hs | ar_hs));

  // New requests after DONE raise err_set, so the error takeover below moves
  // the FSM straight on to ERROR in that cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MON_IDLE:   if (aw_hs || ar_hs) state_d = MON_ACTIVE;
                  else if (end_of_sim_i) state_d = MON_DONE;
      MON_ACTIVE: if (end_of_sim_i) state_d = MON_DRAIN;
      MON_DRAIN:  if ((wr_cnt_next == '0) && (rd_cnt_next == '0)) state_d = MON_DONE;
      MON_DONE:   if (aw_hs || ar_hs) state_d = MON_ACTIVE;
      MON_ERROR:  state_d = MON_ERROR;
      default:    state_d = MON_IDLE;
    endcase
    if (err_set || wd_hit) state_d = MON_ERROR;
  end

  logic                error_q, timeout_q, done_q;
  logic [CntWidth-1:0] wr_done_q, rd_done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= MON_IDLE;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      wr_done_q <= '0;
      rd_done_q <= '0;
    end else begin
      state_q   <= state_d;
      error_q   <= error_q | err_set;
      timeout_q <= timeout_q | wd_hit;
      done_q    <= (state_d == MON_DONE);
      wr_done_q <= wr_done_q + CntWidth'(b_hs);
      rd_done_q <= rd_done_q + CntWidth'(r_last_hs);
    end
  end

`ifdef FLOO_AXI_TXN_MONITOR_STALL_CNT_EN
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  logic [CntWidth-1:0] aw_stall_q, ar_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_stall_q <= '0;
      ar_stall_q <= '0;
    end else begin
      if (aw_valid_i && !aw_ready_i && (aw_stall_q != '1)) aw_stall_q <= aw_stall_q + CntOne;
      if (ar_valid_i && !ar_ready_i && (ar_stall_q != '1)) ar_stall_q <= ar_stall_q + CntOne;
    end
  end

  assign aw_stall_cnt_o = aw_stall_q;
  assign ar_stall_cnt_o = ar_stall_q;
`endif

  assign wr_outstanding_o = wr_cnt;
  assign rd_outstanding_o = rd_cnt;
  assign wr_done_cnt_o    = wr_done_q;
  assign rd_done_cnt_o    = rd_done_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign timeout_o        = timeout_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_floo_axi_txn_monitor.sv
// Bench for floo_axi_txn_monitor: reset check, vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_floo_axi_txn_monitor;
  import floo_test_pkg::*;

  localparam int MAXO = 4;
  localparam int TMO  = 16;
  localparam int CW   = 8;
  localparam int OW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic aw_valid = 0, aw_ready = 0, w_valid = 0, w_ready = 0, w_last = 0;
  logic b_valid = 0, b_ready = 0, ar_valid = 0, ar_ready = 0;
  logic r_valid = 0, r_ready = 0, r_last = 0, end_of_sim = 0;
  logic [OW-1:0] wr_out, rd_out;
  logic [CW-1:0] wr_done, rd_done;
  logic done, error, timeout;
  mon_state_e state;
`ifdef FLOO_AXI_TXN_MONITOR_STALL_CNT_EN
  logic [CW-1:0] aw_stall, ar_stall;
`endif

  floo_axi_txn_monitor #(.MaxOutstanding(MAXO), .TimeoutCycles(TMO), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_i(aw_ready),
    .w_valid_i(w_valid), .w_ready_i(w_ready), .w_last_i(w_last),
    .b_valid_i(b_valid), .b_ready_i(b_ready),
    .ar_valid_i(ar_valid), .ar_ready_i(ar_ready),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
    .end_of_sim_i(end_of_sim),
    .wr_outstanding_o(wr_out), .rd_outstanding_o(rd_out),
    .wr_done_cnt_o(wr_done), .rd_done_cnt_o(rd_done),
    .done_o(done), .error_o(error), .timeout_o(timeout),
`ifdef FLOO_AXI_TXN_MONITOR_STALL_CNT_EN
    .aw_stall_cnt_o(aw_stall), .ar_stall_cnt_o(ar_stall),
`endif
    .state_o(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // scoreboard
  logic [27:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] pack(mon_state_e st, int wr, int rd, logic [7:0] wd,
                                       logic [7:0] rdn, logic dn, logic er, logic to);
    return {st, 3'(wr), 3'(rd), wd, rdn, dn, er, to};
  endfunction

  // transaction-level reference model
  int         m_wr, m_rd, m_run;
  logic [7:0] m_wdone, m_rdone;
  bit         m_err, m_to;
  mon_state_e m_st;

  function automatic void model_reset();
    m_wr = 0; m_rd = 0; m_run = 0; m_wdone = 0; m_rdone = 0;
    m_err = 0; m_to = 0; m_st = MON_IDLE;
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > MAXO) ? MAXO : v);
  endfunction

  function automatic void model_step();
    bit aw, w, b, ar, r, rl;
    if (rst) begin model_reset(); return; end
    aw = aw_valid & aw_ready;  w = w_valid & w_ready;  b = b_valid & b_ready;
    ar = ar_valid & ar_ready;  r = r_valid & r_ready;  rl = r & r_last;
    if ((aw | w | b | ar | r) || (m_wr == 0 && m_rd == 0)) m_run = 0;
    else m_run++;
    if (m_run >= TMO) m_to = 1;
    if ((b && !aw && m_wr == 0) || (aw && !b && m_wr == MAXO) ||
        (rl && !ar && m_rd == 0) || (ar && !rl && m_rd == MAXO) ||
        (m_st == MON_DONE && (aw || ar))) m_err = 1;
    m_wr = clamp(m_wr + int'(aw) - int'(b));
    m_rd = clamp(m_rd + int'(ar) - int'(rl));
    m_wdone = m_wdone + 8'(b);
    m_rdone = m_rdone + 8'(rl);
    if (m_err || m_to) m_st = MON_ERROR;
    else begin
      case (m_st)
        MON_IDLE:   if (aw || ar) m_st = MON_ACTIVE; else if (end_of_sim) m_st = MON_DONE;
        MON_ACTIVE: if (end_of_sim) m_st = MON_DRAIN;
        MON_DRAIN:  if (m_wr == 0 && m_rd == 0) m_st = MON_DONE;
        default: ;
      endcase
    end
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit aw, input bit b, input bit ar, input bit rl, input bit eos);
    aw_valid = aw; aw_ready = aw; b_valid = b; b_ready = b;
    ar_valid = ar; ar_ready = ar; r_valid = rl; r_ready = rl; r_last = rl;
    w_valid = 0; w_ready = 0; w_last = 0; end_of_sim = eos;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1; tick(); tick(); rst = 0;
    model_reset();
  endtask

  typedef struct {
    bit aw, b, ar, rl, eos;
    int e_wr, e_rd, e_wdone, e_rdone;
    mon_state_e e_st;
    bit e_done, e_err;
  } vec_t;

  vec_t vecs[16];
  logic [27:0] got, exp_v;

  initial begin
    vecs[0]  = '{1,0,0,0,0, 1,0,0,0, MON_ACTIVE, 0,0};
    vecs[1]  = '{1,0,0,0,0, 2,0,0,0, MON_ACTIVE, 0,0};
    vecs[2]  = '{1,0,0,0,0, 3,0,0,0, MON_ACTIVE, 0,0};
    vecs[3]  = '{0,1,0,0,0, 2,0,1,0, MON_ACTIVE, 0,0};
    vecs[4]  = '{0,1,0,0,0, 1,0,2,0, MON_ACTIVE, 0,0};
    vecs[5]  = '{0,1,0,0,0, 0,0,3,0, MON_ACTIVE, 0,0};
    vecs[6]  = '{1,0,0,0,0, 1,0,3,0, MON_ACTIVE, 0,0};
    vecs[7]  = '{1,0,0,0,0, 2,0,3,0, MON_ACTIVE, 0,0};
    vecs[8]  = '{1,1,0,0,0, 2,0,4,0, MON_ACTIVE, 0,0};
    vecs[9]  = '{0,1,0,0,0, 1,0,5,0, MON_ACTIVE, 0,0};
    vecs[10] = '{0,1,0,0,0, 0,0,6,0, MON_ACTIVE, 0,0};
    vecs[11] = '{0,0,1,0,0, 0,1,6,0, MON_ACTIVE, 0,0};
    vecs[12] = '{0,0,0,1,0, 0,0,6,1, MON_ACTIVE, 0,0};
    vecs[13] = '{0,0,0,0,1, 0,0,6,1, MON_DRAIN,  0,0};
    vecs[14] = '{0,0,0,0,1, 0,0,6,1, MON_DONE,   1,0};
    vecs[15] = '{0,0,0,0,0, 0,0,6,1, MON_DONE,   1,0};

    do_reset();
    chk("reset_state", pack(state, int'(wr_out), int'(rd_out), wr_done, rd_done, done, error, timeout),
        pack(MON_IDLE, 0, 0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].aw, vecs[i].b, vecs[i].ar, vecs[i].rl, vecs[i].eos);
      tick();
      chk($sformatf("vec%0d_wr", i), 32'(wr_out), 32'(vecs[i].e_wr));
      chk($sformatf("vec%0d_rd", i), 32'(rd_out), 32'(vecs[i].e_rd));
      chk($sformatf("vec%0d_wdone", i), 32'(wr_done), 32'(vecs[i].e_wdone));
      chk($sformatf("vec%0d_rdone", i), 32'(rd_done), 32'(vecs[i].e_rdone));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_st));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d_err", i), 32'(error), 32'(vecs[i].e_err));
    end

    // write underflow, then ERROR must absorb further traffic
    do_reset();
    drive(0, 1, 0, 0, 0); tick();
    chk("uf_err", 32'(error), 32'd1);
    chk("uf_state", 32'(state), 32'(MON_ERROR));
    chk("uf_wr", 32'(wr_out), 32'd0);
    drive(1, 0, 0, 0, 0); tick(); tick();
    chk("uf_absorb_state", 32'(state), 32'(MON_ERROR));
    chk("uf_absorb_wr", 32'(wr_out), 32'd2);

    // watchdog: one AR, then silence
    do_reset();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k < TMO; k++) tick();
    chk("to_before", 32'(timeout), 32'd0);
    tick();
    chk("to_at", 32'(timeout), 32'd1);
    chk("to_state", 32'(state), 32'(MON_ERROR));
    drive(0, 0, 0, 1, 0); tick();
    chk("to_sticky", 32'(timeout), 32'd1);
    chk("to_rd", 32'(rd_out), 32'd0);
    chk("to_no_err", 32'(error), 32'd0);

    // drain with two reads outstanding
    do_reset();
    drive(0, 0, 1, 0, 0); tick(); tick();
    drive(0, 0, 0, 0, 1); tick();
    chk("drain_state", 32'(state), 32'(MON_DRAIN));
    drive(0, 0, 0, 1, 1); tick();
    chk("drain_rd1", 32'(rd_out), 32'd1);
    chk("drain_done0", 32'(done), 32'd0);
    tick();
    chk("drain_rd0", 32'(rd_out), 32'd0);
    chk("drain_done1", 32'(done), 32'd1);

    // write overflow at MaxOutstanding
    do_reset();
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < MAXO; k++) tick();
    chk("of_full", 32'(wr_out), 32'(MAXO));
    chk("of_err0", 32'(error), 32'd0);
    tick();
    chk("of_sat", 32'(wr_out), 32'(MAXO));
    chk("of_err1", 32'(error), 32'd1);

    // end_of_sim with nothing issued, then late traffic
    do_reset();
    drive(0, 0, 0, 0, 1); tick();
    chk("idle_done", 32'(done), 32'd1);
    drive(0, 0, 1, 0, 1); tick();
    chk("late_err", 32'(error), 32'd1);
    chk("late_state", 32'(state), 32'(MON_ERROR));
    chk("late_done", 32'(done), 32'd0);

`ifdef FLOO_AXI_TXN_MONITOR_STALL_CNT_EN
    do_reset();
    aw_valid = 1; aw_ready = 0;
    for (int k = 0; k < 5; k++) tick();
    aw_valid = 0; tick();
    chk("aw_stall", 32'(aw_stall), 32'd5);
    chk("ar_stall", 32'(ar_stall), 32'd0);
`endif

    // randomized traffic
    do_reset();
    begin
      int quiet = 0;
      for (int c = 0; c < 4000; c++) begin
        rst = ($urandom_range(0, 249) == 0) || (m_st == MON_ERROR && $urandom_range(0, 19) == 0);
        if (quiet > 0) begin
          drive(0, 0, 0, 0, 0);
          quiet--;
        end else begin
          aw_valid = (m_wr < MAXO) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
          aw_ready = $urandom_range(0, 1);
          ar_valid = (m_rd < MAXO) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
          ar_ready = $urandom_range(0, 1);
          w_valid = $urandom_range(0, 1); w_ready = $urandom_range(0, 1); w_last = $urandom_range(0, 1);
          b_valid = (m_wr > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 299) == 0);
          b_ready = $urandom_range(0, 1);
          r_valid = $urandom_range(0, 1); r_ready = $urandom_range(0, 1);
          r_last = (m_rd > 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 299) == 0);
          end_of_sim = ($urandom_range(0, 59) == 0);
          if ($urandom_range(0, 149) == 0) quiet = 20;
        end
        model_step();
        exp_q.push_back(pack(m_st, m_wr, m_rd, m_wdone, m_rdone, m_st == MON_DONE, m_err, m_to));
        tick();
        got = pack(state, int'(wr_out), int'(rd_out), wr_done, rd_done, done, error, timeout);
        exp_v = exp_q.pop_front();
        chk($sformatf("rand_c%0d", c), 32'(got), 32'(exp_v));
      end
    end
    rst = 0;

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
